// File: rtl/time_delay_module_pkg.sv
// Shared constants and helpers for the time_delay_module slice.
package time_delay_module_pkg;

    localparam int GET_DLY_DEF  = 5;
    localparam int LOSE_DLY_DEF = 20;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/time_delay_module_inertial_filter.sv
// Inertial filter: a level must hold LOSE_DLY cycles before dout follows it.
module inertial_filter
    import time_delay_module_pkg::*;
#(
    parameter int LOSE_DLY = LOSE_DLY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = cnt_width(LOSE_DLY);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;

    // Any return to the current output level restarts the window.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (din == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(LOSE_DLY - 1)) begin
            dout_d = din;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/time_delay_module.sv
// Registered, transport-delayed and inertially-delayed views of ai & bi.
module time_delay_module
    import time_delay_module_pkg::*;
#(
    parameter int GET_DLY  = GET_DLY_DEF,
    parameter int LOSE_DLY = LOSE_DLY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ai,
    input  logic bi,
    output logic so_lose,
    output logic so_get,
    output logic so_normal
);

    logic               normal_q, normal_d;
    logic [GET_DLY-1:0] sr_q, sr_d;

    // Stage 0 takes so_normal; the last stage is so_get.
    always_comb begin
        normal_d = ai & bi;
        sr_d[0]  = normal_q;
        for (int i = 1; i < GET_DLY; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            normal_q <= 1'b0;
            sr_q     <= '0;
        end else begin
            normal_q <= normal_d;
            sr_q     <= sr_d;
        end
    end

    inertial_filter #(
        .LOSE_DLY(LOSE_DLY)
    ) u_lose (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (normal_q),
        .dout (so_lose)
    );

    assign so_normal = normal_q;
    assign so_get    = sr_q[GET_DLY-1];

endmodule

// File: tb/tb_time_delay_module.sv
// Directed bench for time_delay_module with default delays (5 / 20).
`timescale 1ns/1ps
module tb_time_delay_module;

    logic clk, rst_n, ai, bi;
    logic so_lose, so_get, so_normal;

    time_delay_module dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ai       (ai),
        .bi       (bi),
        .so_lose  (so_lose),
        .so_get   (so_get),
        .so_normal(so_normal)
    );

    initial begin
        clk = 1'b0;
        forever #0.5 clk = ~clk;
    end

    typedef bit trace_t [100];

    typedef struct {
        int len;
        int n_rise;
        int n_w;
        int g_rise;
        int g_w;
        int l_rise;
        int l_w;
    } vec_t;

    trace_t sa, sb, tn, tg, tl;
    int     checks, failures;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int first_hi(input trace_t t, input int w);
        for (int i = 0; i < w; i++) if (t[i]) return i;
        return -1;
    endfunction

    function automatic int count_hi(input trace_t t, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) if (t[i]) n++;
        return n;
    endfunction

    // Call at a negedge; trace[c] is sampled before cycle c's inputs apply.
    task automatic capture(input int w);
        for (int c = 0; c < w; c++) begin
            tn[c] = so_normal;
            tg[c] = so_get;
            tl[c] = so_lose;
            ai    = sa[c];
            bi    = sb[c];
            @(negedge clk);
        end
    endtask

    task automatic set_pulse(input int len);
        for (int c = 0; c < 100; c++) begin
            sa[c] = (c < len);
            sb[c] = (c < len);
        end
    endtask

    vec_t vecs [5];

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{1,  1, 1,  6, 1,  -1, 0};
        vecs[1] = '{10, 1, 10, 6, 10, -1, 0};
        vecs[2] = '{19, 1, 19, 6, 19, -1, 0};
        vecs[3] = '{20, 1, 20, 6, 20, 21, 20};
        vecs[4] = '{35, 1, 35, 6, 35, 21, 35};

        rst_n = 1'b0;
        ai    = 1'b1;
        bi    = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_normal", so_normal, 0);
        chk("rst_get", so_get, 0);
        chk("rst_lose", so_lose, 0);

        rst_n = 1'b1;
        set_pulse(30);
        capture(90);
        chk("rel_n_rise", first_hi(tn, 90), 1);
        chk("rel_g_rise", first_hi(tg, 90), 6);
        chk("rel_l_rise", first_hi(tl, 90), 21);
        chk("rel_l_w", count_hi(tl, 90), 30);

        foreach (vecs[i]) begin
            set_pulse(vecs[i].len);
            capture(90);
            chk($sformatf("v%0d_n_rise", vecs[i].len), first_hi(tn, 90), vecs[i].n_rise);
            chk($sformatf("v%0d_n_w", vecs[i].len), count_hi(tn, 90), vecs[i].n_w);
            chk($sformatf("v%0d_g_rise", vecs[i].len), first_hi(tg, 90), vecs[i].g_rise);
            chk($sformatf("v%0d_g_w", vecs[i].len), count_hi(tg, 90), vecs[i].g_w);
            chk($sformatf("v%0d_l_rise", vecs[i].len), first_hi(tl, 90), vecs[i].l_rise);
            chk($sformatf("v%0d_l_w", vecs[i].len), count_hi(tl, 90), vecs[i].l_w);
        end

        // 50-cycle high with a 3-cycle bi-only gap in the middle.
        set_pulse(50);
        for (int c = 24; c < 27; c++) sb[c] = 1'b0;
        capture(90);
        chk("gl_n_w", count_hi(tn, 90), 47);
        chk("gl_g_rise", first_hi(tg, 90), 6);
        chk("gl_g_w", count_hi(tg, 90), 47);
        chk("gl_g_29", tg[29], 1);
        chk("gl_g_30", tg[30], 0);
        chk("gl_g_32", tg[32], 0);
        chk("gl_g_33", tg[33], 1);
        chk("gl_l_rise", first_hi(tl, 90), 21);
        chk("gl_l_w", count_hi(tl, 90), 50);

        // Asynchronous reset between edges while pulses are in flight.
        ai = 1'b1;
        bi = 1'b1;
        repeat (12) @(posedge clk);
        #0.2;
        chk("ar_pre_normal", so_normal, 1);
        chk("ar_pre_get", so_get, 1);
        chk("ar_pre_lose", so_lose, 0);
        rst_n = 1'b0;
        #0.1;
        chk("ar_normal", so_normal, 0);
        chk("ar_get", so_get, 0);
        chk("ar_lose", so_lose, 0);
        ai = 1'b0;
        bi = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_pulse(0);
        capture(40);
        chk("ar_post_normal", count_hi(tn, 40), 0);
        chk("ar_post_get", count_hi(tg, 40), 0);
        chk("ar_post_lose", count_hi(tl, 40), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
